// File: rtl/rob_pr_free_q_if.sv
// Handshake bundle between the ROB commit port, the freed-PR queue and the banked free_list.
// The queue uses the slave view: it consumes commit bundles and offers one PR per free_list bank.
interface rob_pr_free_q_if #(
    parameter int LANES = 4,
    parameter int PR_W  = 7,
    parameter int BANKS = 4,
    parameter int UPR_W = 5
);
    logic                          enq_valid;
    logic [LANES-1:0]              enq_mask_by_lane;
    logic [LANES-1:0][PR_W-1:0]    enq_PR_by_lane;
    logic                          enq_ready;
    logic [BANKS-1:0]              deq_valid_by_bank;
    logic [BANKS-1:0][UPR_W-1:0]   deq_upper_PR_by_bank;
    logic [BANKS-1:0]              deq_ready_by_bank;

    modport master (
        output enq_valid, enq_mask_by_lane, enq_PR_by_lane, deq_ready_by_bank,
        input  enq_ready, deq_valid_by_bank, deq_upper_PR_by_bank
    );

    modport slave (
        input  enq_valid, enq_mask_by_lane, enq_PR_by_lane, deq_ready_by_bank,
        output enq_ready, deq_valid_by_bank, deq_upper_PR_by_bank
    );
endinterface

// File: rtl/rob_pr_free_q.sv
// Freed-PR queue: buffers ROB commit bundles and drains them one PR per free_list bank per cycle,
// resolving same-bank lanes in a bundle over successive cycles in ascending lane order.
module rob_pr_free_q #(
    parameter int ENTRIES  = 2,
    parameter int LANES    = 4,
    parameter int PR_COUNT = 128,
    parameter int BANKS    = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    rob_pr_free_q_if.slave      bus
);
    localparam int PR_W      = $clog2(PR_COUNT);
    localparam int LOG_BANKS = $clog2(BANKS);
    localparam int UPR_W     = PR_W - LOG_BANKS;
    localparam int PTR_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W     = $clog2(ENTRIES + 1);

    logic [PR_W-1:0]   r_pr  [ENTRIES][LANES];
    logic [LANES-1:0]  r_rem [ENTRIES];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [PR_W-1:0]             w_head_pr   [LANES];
    logic [LOG_BANKS-1:0]        w_lane_bank [LANES];
    logic [LANES-1:0]            w_head_rem;
    logic [LANES-1:0]            w_clr;
    logic [LANES-1:0]            w_rem_after;
    logic [BANKS-1:0]            w_deq_vld;
    logic [BANKS-1:0][UPR_W-1:0] w_deq_upr;
    logic [BANKS-1:0]            w_bank_any;
    logic                        w_found;
    logic                        w_not_empty;
    logic                        w_enq_ready;
    logic                        w_enq_fire;
    logic                        w_pop;
    logic [PTR_W-1:0]            w_head_inc;
    logic [PTR_W-1:0]            w_tail_inc;

    assign w_head_rem  = r_rem[r_head];
    assign w_not_empty = (r_count != '0);
    assign w_enq_ready = (r_count < CNT_W'(ENTRIES));
    assign w_enq_fire  = bus.enq_valid && w_enq_ready && (|bus.enq_mask_by_lane);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_head_pr[gi]   = r_pr[r_head][gi];
        assign w_lane_bank[gi] = r_pr[r_head][gi][LOG_BANKS-1:0];
    end

    // Independent bank-hit summary, used only to cross-check the candidate selection.
    for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank_any
        logic [LANES-1:0] w_match;
        for (genvar gl = 0; gl < LANES; gl++) begin : g_match
            assign w_match[gl] = w_head_rem[gl] && (w_lane_bank[gl] == LOG_BANKS'(gi));
        end
        assign w_bank_any[gi] = w_not_empty && (|w_match);
    end

    // Per bank, the lowest still-remaining lane of the head slot is the candidate.
    always_comb begin
        w_clr     = '0;
        w_deq_vld = '0;
        w_deq_upr = '0;
        w_found   = 1'b0;
        for (int b = 0; b < BANKS; b++) begin
            w_found = 1'b0;
            for (int l = 0; l < LANES; l++) begin
                if (!w_found && w_not_empty && w_head_rem[l] &&
                    (w_lane_bank[l] == LOG_BANKS'(b))) begin
                    w_found      = 1'b1;
                    w_deq_vld[b] = 1'b1;
                    w_deq_upr[b] = w_head_pr[l][PR_W-1:LOG_BANKS];
                    if (bus.deq_ready_by_bank[b]) begin
                        w_clr[l] = 1'b1;
                    end
                end
            end
        end
    end

    assign w_rem_after = w_head_rem & ~w_clr;
    assign w_pop       = w_not_empty && (w_rem_after == '0);
    assign w_head_inc  = (r_head == PTR_W'(ENTRIES - 1)) ? '0 : r_head + PTR_W'(1);
    assign w_tail_inc  = (r_tail == PTR_W'(ENTRIES - 1)) ? '0 : r_tail + PTR_W'(1);

    assign bus.enq_ready            = w_enq_ready;
    assign bus.deq_valid_by_bank    = w_deq_vld;
    assign bus.deq_upper_PR_by_bank = w_deq_upr;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                r_rem[e] <= '0;
                for (int l = 0; l < LANES; l++) begin
                    r_pr[e][l] <= '0;
                end
            end
        end else begin
            if (w_not_empty) begin
                r_rem[r_head] <= w_rem_after;
            end
            // Head and tail only coincide here when empty (no clears) or full (no enqueue).
            if (w_enq_fire) begin
                r_rem[r_tail] <= bus.enq_mask_by_lane;
                for (int l = 0; l < LANES; l++) begin
                    r_pr[r_tail][l] <= bus.enq_PR_by_lane[l];
                end
                r_tail <= w_tail_inc;
            end
            if (w_pop) begin
                r_head <= w_head_inc;
            end
            case ({w_enq_fire, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            assert (!(w_enq_fire && (r_count == CNT_W'(ENTRIES))))
                else $error("rob_pr_free_q: enqueue while full");
            assert ((w_deq_vld & ~w_bank_any) == '0)
                else $error("rob_pr_free_q: deq_valid without matching lane");
        end
    end
endmodule
